// File: rtl/serial_pkg.sv
// Shared types and constants for the nibble serializer.
// Holds the FSM state encoding and the default word width.
package serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/nibble_serializer.sv
// Parallel-to-serial converter with valid/ready intake and frame counter.
// Define NIBBLE_SERIALIZER_PARITY_EN to append an even-parity bit per frame.
module nibble_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             x_o,
  output logic             bit_valid_o,
  output logic             last_o,
  output logic [7:0]       words_o
);

`ifdef NIBBLE_SERIALIZER_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif
  localparam int CW = $clog2(FL + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(FL - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_nxt;
  logic             shifting;
  logic             is_last;
  logic             accept;
  logic             data_bit;

  assign shifting = (state_q == SHIFT);
  assign is_last  = shifting && (cnt_q == LAST_IDX);
  assign ready_o  = !shifting || is_last;
  assign accept   = valid_i && ready_o;

  assign data_bit = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
  assign sreg_nxt = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                              : {1'b0, sreg_q[WIDTH-1:1]};

`ifdef NIBBLE_SERIALIZER_PARITY_EN
  logic par_q;

  // Latch even parity of the word so it can trail the data bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      par_q <= 1'b0;
    else if (accept) par_q <= ^data_i;
  end

  assign x_o = shifting &&
               ((cnt_q == LAST_IDX) ? par_q : data_bit);
`else
  assign x_o = shifting && data_bit;
`endif

  assign bit_valid_o = shifting;
  assign last_o      = is_last;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: a same-cycle accept on the last bit keeps shifting.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = SHIFT;
      SHIFT: if (is_last && !accept) state_d = IDLE;
    endcase
  end

  // Shift register and bit index; cleared between frames.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else if (accept) begin
      sreg_q <= data_i;
      cnt_q  <= '0;
    end else if (shifting) begin
      if (is_last) begin
        sreg_q <= '0;
        cnt_q  <= '0;
      end else begin
        sreg_q <= sreg_nxt;
        cnt_q  <= cnt_q + CW'(1);
      end
    end
  end

  // Count a frame as complete on the edge that ends its last bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       words_o <= 8'd0;
    else if (is_last) words_o <= words_o + 8'd1;
  end

endmodule

// File: tb/tb_nibble_serializer.sv
// Randomized and directed bench for nibble_serializer.
// Two instances (MSB-first, LSB-first) share stimulus; a queue model checks them.
module tb_nibble_serializer;

`ifdef NIBBLE_SERIALIZER_PARITY_EN
  localparam int FL = 5;
`else
  localparam int FL = 4;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] data = 4'd0;
  logic       valid = 1'b0;

  logic       rdy_m, x_m, bv_m, last_m;
  logic       rdy_l, x_l, bv_l, last_l;
  logic [7:0] words_m, words_l;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nibble_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .data_i(data), .valid_i(valid),
    .ready_o(rdy_m), .x_o(x_m), .bit_valid_o(bv_m),
    .last_o(last_m), .words_o(words_m)
  );

  nibble_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .data_i(data), .valid_i(valid),
    .ready_o(rdy_l), .x_o(x_l), .bit_valid_o(bv_l),
    .last_o(last_l), .words_o(words_l)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queues of bits still to be emitted for the current frame(s).
  bit       qm[$];
  bit       ql[$];
  bit [7:0] mw;

  function automatic bit m_ready();
    return qm.size() <= 1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      qm.delete();
      ql.delete();
      mw = 8'd0;
    end else begin
      bit acc;
      acc = valid && m_ready();
      if (qm.size() > 0) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
        if (qm.size() == 0) mw = mw + 8'd1;
      end
      if (acc) begin
        for (int i = 0; i < 4; i++) begin
          qm.push_back(data[3-i]);
          ql.push_back(data[i]);
        end
`ifdef NIBBLE_SERIALIZER_PARITY_EN
        qm.push_back(^data);
        ql.push_back(^data);
`endif
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (reset) begin
      bit en, em, el, ls;
      en = qm.size() > 0;
      em = en ? qm[0] : 1'b0;
      el = en ? ql[0] : 1'b0;
      ls = qm.size() == 1;
      chk("ready_m", rdy_m, m_ready());
      chk("ready_l", rdy_l, m_ready());
      chk("bv_m", bv_m, en);
      chk("bv_l", bv_l, en);
      chk("x_m", x_m, em);
      chk("x_l", x_l, el);
      chk("last_m", last_m, ls);
      chk("last_l", last_l, ls);
      chk("words_m", words_m, mw);
      chk("words_l", words_l, mw);
    end
  end

  // Present a word at a negedge and hold it until accepted.
  task automatic send(input logic [3:0] d);
    int n;
    bit r;
    n = 0;
    data = d;
    valid = 1'b1;
    forever begin
      r = m_ready();
      @(negedge clk);
      n++;
      if (r) break;
      if (n > 50) begin
        chk("send_timeout", 1, 0);
        break;
      end
    end
    valid = 1'b0;
  endtask

  task automatic capture(output logic [FL-1:0] bm,
                         output logic [FL-1:0] bl,
                         output logic [FL-1:0] ls);
    for (int i = 0; i < FL; i++) begin
      if (i > 0) @(negedge clk);
      bm[FL-1-i] = x_m;
      bl[FL-1-i] = x_l;
      ls[FL-1-i] = last_m;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  logic [FL-1:0] bm, bl, ls;
  logic [FL-1:0] last_pat;

`ifdef NIBBLE_SERIALIZER_PARITY_EN
  localparam logic [3:0]    D1 = 4'b1011;
  localparam logic [FL-1:0] M1 = 5'b10111;
  localparam logic [FL-1:0] L1 = 5'b11011;
  localparam logic [3:0]    D2 = 4'b0001;
  localparam logic [FL-1:0] M2 = 5'b00011;
  localparam logic [FL-1:0] L2 = 5'b10001;
  localparam logic [FL-1:0] M3 = 5'b00110;
`else
  localparam logic [3:0]    D1 = 4'b1010;
  localparam logic [FL-1:0] M1 = 4'b1010;
  localparam logic [FL-1:0] L1 = 4'b0101;
  localparam logic [3:0]    D2 = 4'b0001;
  localparam logic [FL-1:0] M2 = 4'b0001;
  localparam logic [FL-1:0] L2 = 4'b1000;
  localparam logic [FL-1:0] M3 = 4'b0011;
`endif

  initial begin
    last_pat = FL'(1);
    #2;
    chk("rst_x", x_m, 0);
    chk("rst_bv", bv_m, 0);
    chk("rst_last", last_m, 0);
    chk("rst_words", words_m, 0);
    chk("rst_ready", rdy_m, 1);
    @(negedge clk);
    reset = 1'b1;

    // Single word, both bit orders.
    send(D1);
    capture(bm, bl, ls);
    chk("w1_msb_bits", bm, M1);
    chk("w1_lsb_bits", bl, L1);
    chk("w1_last", ls, last_pat);
    @(negedge clk);
    chk("w1_words", words_m, 1);
    chk("w1_idle_bv", bv_m, 0);

    send(D2);
    capture(bm, bl, ls);
    chk("w2_msb_bits", bm, M2);
    chk("w2_lsb_bits", bl, L2);
    @(negedge clk);
    chk("w2_words", words_l, 2);

    // Back-to-back A then 5.
    send(4'hA);
    send(4'h5);
    chk("b2b_bv", bv_m, 1);
    chk("b2b_x0", x_m, 0);
    repeat (FL) @(negedge clk);
    chk("b2b_words", words_m, 4);

    // Reset mid-frame.
    send(4'hF);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_x", x_m, 0);
    chk("mid_rst_bv", bv_m, 0);
    chk("mid_rst_last", last_m, 0);
    chk("mid_rst_words", words_m, 0);
    chk("mid_rst_ready", rdy_m, 1);
    @(negedge clk);
    reset = 1'b1;
    send(4'h3);
    capture(bm, bl, ls);
    chk("post_rst_bits", bm, M3);
    @(negedge clk);
    chk("post_rst_words", words_m, 1);

    // 256 frames wrap the counter.
    do_reset();
    for (int i = 0; i < 256; i++) send(4'($urandom));
    chk("wrap_255", words_m, 255);
    repeat (FL) @(negedge clk);
    chk("wrap_0", words_m, 0);

    // Random traffic, including valid pulses while busy.
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      valid = ($urandom % 5) != 0;
      data = 4'($urandom);
    end
    valid = 1'b0;
    repeat (2 * FL) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
